// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and the control bundle layout for pipe_ctrl_unit.
// A stage bundle is {alu_op[ALUOP_W-1:0], ctrl_t}; ctrl_t occupies the low CTRL_FIX_W bits.
`timescale 1ns/1ps
package pipe_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LH     = 6'h21;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_LBU    = 6'h24;
    localparam logic [5:0] OP_LHU    = 6'h25;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SH     = 6'h29;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam int ALU_OP_W = 4;
    localparam logic [3:0] ALU_NONE = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_LUI  = 4'd7;
    localparam logic [3:0] ALU_ADDU = 4'd8;

    localparam logic       SRCB_REG  = 1'b0;
    localparam logic       SRCB_IMM  = 1'b1;
    localparam logic [1:0] IMM_SIGN  = 2'd0;
    localparam logic [1:0] IMM_ZERO  = 2'd1;
    localparam logic [1:0] IMM_UPPER = 2'd2;

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BLEZ = 3'd3;
    localparam logic [2:0] BR_BGTZ = 3'd4;
    localparam logic [2:0] BR_BGEZ = 3'd5;

    localparam logic [1:0] JMP_NONE = 2'd0;
    localparam logic [1:0] JMP_J    = 2'd1;
    localparam logic [1:0] JMP_JAL  = 2'd2;
    localparam logic [1:0] JMP_JR   = 2'd3;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC8 = 2'd2;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef struct packed {
        logic       alusrcb;
        logic [1:0] immext;
        logic [2:0] br;
        logic [1:0] jmp;
        logic       memwrite;
        logic       memhalf;
        logic       membyte;
        logic       memext;
        logic       memread;
        logic       regwrite;
        logic [1:0] wbsel;
    } ctrl_t;

    localparam int    CTRL_FIX_W = $bits(ctrl_t);
    localparam ctrl_t NOP_CTRL   = '0;

    // Bit positions inside a flat bundle, used by the hazard compare.
    localparam int RW_BIT = 2;
    localparam int MR_BIT = 3;

endpackage

// File: rtl/pipe_ctrl_decode.sv
// Combinational op/func decode: control bundle, destination, source usage and illegal flag.
`timescale 1ns/1ps
module pipe_ctrl_decode
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int ALUOP_W  = 4,
    parameter int LINK_REG = 31
) (
    input  logic [5:0]         op,
    input  logic [5:0]         func,
    input  logic [REG_AW-1:0]  rt,
    input  logic [REG_AW-1:0]  rd,
    output ctrl_t              ctrl,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [REG_AW-1:0]  dst,
    output logic               uses_rs,
    output logic               uses_rt,
    output logic               ill
);

    ctrl_t             c;
    logic [3:0]        alu;
    logic [REG_AW-1:0] d;
    logic              urs;
    logic              urt;
    logic              bad;

    always_comb begin
        c   = NOP_CTRL;
        alu = ALU_NONE;
        d   = '0;
        urs = 1'b1;
        urt = 1'b0;
        bad = 1'b0;
        case (op)
            OP_RTYPE: begin
                urt        = 1'b1;
                d          = rd;
                c.regwrite = 1'b1;
                case (func)
                    FN_ADD:  alu = ALU_ADD;
                    FN_ADDU: alu = ALU_ADDU;
                    FN_SUB:  alu = ALU_SUB;
                    FN_AND:  alu = ALU_AND;
                    FN_OR:   alu = ALU_OR;
                    FN_SLT:  alu = ALU_SLT;
                    FN_JR: begin
                        c.jmp      = JMP_JR;
                        c.regwrite = 1'b0;
                    end
                    default: bad = 1'b1;
                endcase
            end
            OP_LUI: begin
                urs        = 1'b0;
                alu        = ALU_LUI;
                c.alusrcb  = SRCB_IMM;
                c.immext   = IMM_UPPER;
                c.regwrite = 1'b1;
                d          = rt;
            end
            OP_SLTI, OP_ADDI, OP_ADDIU, OP_ORI, OP_XORI: begin
                c.alusrcb  = SRCB_IMM;
                c.regwrite = 1'b1;
                d          = rt;
                case (op)
                    OP_SLTI:  alu = ALU_SLT;
                    OP_ADDI:  alu = ALU_ADD;
                    OP_ADDIU: alu = ALU_ADDU;
                    OP_ORI: begin
                        alu      = ALU_OR;
                        c.immext = IMM_ZERO;
                    end
                    default: begin
                        alu      = ALU_XOR;
                        c.immext = IMM_ZERO;
                    end
                endcase
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                alu        = ALU_ADD;
                c.alusrcb  = SRCB_IMM;
                c.memread  = 1'b1;
                c.regwrite = 1'b1;
                c.wbsel    = WB_MEM;
                c.membyte  = (op == OP_LB) || (op == OP_LBU);
                c.memhalf  = (op == OP_LH) || (op == OP_LHU);
                c.memext   = (op == OP_LB) || (op == OP_LH);
                d          = rt;
            end
            OP_SB, OP_SH, OP_SW: begin
                urt        = 1'b1;
                alu        = ALU_ADD;
                c.alusrcb  = SRCB_IMM;
                c.memwrite = 1'b1;
                c.membyte  = (op == OP_SB);
                c.memhalf  = (op == OP_SH);
            end
            OP_BEQ, OP_BNE: begin
                urt  = 1'b1;
                alu  = ALU_SUB;
                c.br = (op == OP_BEQ) ? BR_BEQ : BR_BNE;
            end
            OP_BLEZ, OP_BGTZ, OP_REGIMM: begin
                alu = ALU_SUB;
                case (op)
                    OP_BLEZ: c.br = BR_BLEZ;
                    OP_BGTZ: c.br = BR_BGTZ;
                    default: c.br = BR_BGEZ;
                endcase
            end
            OP_J: begin
                urs   = 1'b0;
                c.jmp = JMP_J;
            end
            OP_JAL: begin
                urs        = 1'b0;
                c.jmp      = JMP_JAL;
                c.regwrite = 1'b1;
                c.wbsel    = WB_PC8;
                d          = REG_AW'(LINK_REG);
            end
            default: bad = 1'b1;
        endcase

        // r0 is never a real destination, so it must not look like a producer.
        if (!c.regwrite || d == '0) begin
            c.regwrite = 1'b0;
            d          = '0;
        end

        if (bad) begin
            c   = NOP_CTRL;
            alu = ALU_NONE;
            d   = '0;
            urs = 1'b0;
            urt = 1'b0;
        end
    end

    assign ctrl    = c;
    assign alu_op  = ALUOP_W'(alu);
    assign dst     = d;
    assign uses_rs = urs;
    assign uses_rt = urt;
    assign ill     = bad;

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: ID decode, EX/MEM/WB control registers, hazard stall/flush.
// Define PIPE_CTRL_FWD_EN to enable forwarding selects and load-use-only stalling.
`timescale 1ns/1ps
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int ALUOP_W   = 4,
    parameter int LINK_REG  = 31,
    parameter int WB_BYPASS = 1,
    localparam int CTRL_W   = ALUOP_W + CTRL_FIX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [5:0]        id_op,
    input  logic [5:0]        id_func,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              flush,
    output logic              stall,
    output logic              id_ill,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [REG_AW-1:0] ex_dst,
    output logic              mem_valid,
    output logic [CTRL_W-1:0] mem_ctrl,
    output logic [REG_AW-1:0] mem_dst,
    output logic              wb_valid,
    output logic [CTRL_W-1:0] wb_ctrl,
    output logic [REG_AW-1:0] wb_dst,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);

    ctrl_t              dec_ctrl;
    logic [ALUOP_W-1:0] dec_alu;
    logic [REG_AW-1:0]  dec_dst;
    logic               dec_urs;
    logic               dec_urt;
    logic               dec_ill;
    logic               match_rs;
    logic               match_rt;
    logic               haz;
    logic               take;

    pipe_ctrl_decode #(
        .REG_AW   (REG_AW),
        .ALUOP_W  (ALUOP_W),
        .LINK_REG (LINK_REG)
    ) u_decode (
        .op      (id_op),
        .func    (id_func),
        .rt      (id_rt),
        .rd      (id_rd),
        .ctrl    (dec_ctrl),
        .alu_op  (dec_alu),
        .dst     (dec_dst),
        .uses_rs (dec_urs),
        .uses_rt (dec_urt),
        .ill     (dec_ill)
    );

    function automatic logic hit(input logic v, input logic rw,
                                 input logic [REG_AW-1:0] d, input logic [REG_AW-1:0] s);
        return v & rw & (d == s) & (s != '0);
    endfunction

`ifdef PIPE_CTRL_FWD_EN
    // Only a load in EX cannot be bypassed; everything later is forwarded.
    assign match_rs = hit(ex_valid & ex_ctrl[MR_BIT], ex_ctrl[RW_BIT], ex_dst, id_rs);
    assign match_rt = hit(ex_valid & ex_ctrl[MR_BIT], ex_ctrl[RW_BIT], ex_dst, id_rt);

    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (hit(mem_valid, mem_ctrl[RW_BIT], mem_dst, id_rs))
            fwd_a = FWD_MEM;
        else if (hit(wb_valid, wb_ctrl[RW_BIT], wb_dst, id_rs))
            fwd_a = FWD_WB;
        if (hit(mem_valid, mem_ctrl[RW_BIT], mem_dst, id_rt))
            fwd_b = FWD_MEM;
        else if (hit(wb_valid, wb_ctrl[RW_BIT], wb_dst, id_rt))
            fwd_b = FWD_WB;
    end
`else
    localparam logic WB_CMP = (WB_BYPASS == 0);

    assign match_rs = hit(ex_valid, ex_ctrl[RW_BIT], ex_dst, id_rs)
                    | hit(mem_valid, mem_ctrl[RW_BIT], mem_dst, id_rs)
                    | (WB_CMP & hit(wb_valid, wb_ctrl[RW_BIT], wb_dst, id_rs));
    assign match_rt = hit(ex_valid, ex_ctrl[RW_BIT], ex_dst, id_rt)
                    | hit(mem_valid, mem_ctrl[RW_BIT], mem_dst, id_rt)
                    | (WB_CMP & hit(wb_valid, wb_ctrl[RW_BIT], wb_dst, id_rt));
    assign fwd_a = FWD_RF;
    assign fwd_b = FWD_RF;
`endif

    assign haz    = id_valid & ((dec_urs & match_rs) | (dec_urt & match_rt));
    assign stall  = haz & ~flush;
    assign id_ill = id_valid & dec_ill;
    // Flush, hazard, invalid and illegal all turn the EX slot into a bubble.
    assign take   = id_valid & ~dec_ill & ~flush & ~haz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid  <= 1'b0;
            ex_ctrl   <= '0;
            ex_dst    <= '0;
            mem_valid <= 1'b0;
            mem_ctrl  <= '0;
            mem_dst   <= '0;
            wb_valid  <= 1'b0;
            wb_ctrl   <= '0;
            wb_dst    <= '0;
        end else begin
            ex_valid  <= take;
            ex_ctrl   <= take ? {dec_alu, dec_ctrl} : '0;
            ex_dst    <= take ? dec_dst : '0;
            mem_valid <= ex_valid;
            mem_ctrl  <= ex_ctrl;
            mem_dst   <= ex_dst;
            wb_valid  <= mem_valid;
            wb_ctrl   <= mem_ctrl;
            wb_dst    <= mem_dst;
        end
    end

endmodule
